mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined 32x32 low-word multiplier cell among NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels; operands are registered into the cell; results return on a single tagged response channel.
- The multiplier cell cannot stall, so a credit-managed result FIFO absorbs response backpressure without losing results.
- Sits between the processor-side multiply users and the multiplier cell.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; equals clog2(NUM_REQ).
- MUL_LATENCY, 1, cycles from operands presented on mul_src1/mul_src2 to a valid mul_result.
- FIFO_DEPTH, 4, result FIFO entries; must be >= MUL_LATENCY+3 for full throughput.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_src1  in  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_src2  in  NUM_REQ*32  operand B; same packing as req_src1.
- mul_src1  out  32  registered operand A to the multiplier cell.
- mul_src2  out  32  registered operand B to the multiplier cell.
- mul_result  in  32  multiplier cell result (low 32 bits of the product).
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer accept.
- resp_id  out  ID_W  index of the requester that owns resp_data.
- resp_data  out  32  product mod 2^32.
- busy  out  1  any operation in flight or buffered.

Behaviour:
- Reset (asynchronous, active-high):
  - In-flight pipeline valids and FIFO are cleared; in-flight results are discarded.
  - Credit counter = FIFO_DEPTH; round-robin pointer = 0.
  - mul_src1 = mul_src2 = 0; resp_valid = 0; busy = 0.
  - req_ready is forced to 0 while reset is high.
- Credits:
  - Decrement by 1 on accept (any req_valid & req_ready); increment by 1 on a response pop (resp_valid & resp_ready).
  - Accept and pop in the same cycle leave credits unchanged.
  - No accept is possible when credits = 0. Credits never exceed FIFO_DEPTH or go below 0.
- Arbitration:
  - When credits > 0, grant the first requester with req_valid high, searching from the pointer upward modulo NUM_REQ.
  - req_ready[g] = 1 only for the granted requester g, combinationally.
  - After an accept from g, pointer = (g+1) mod NUM_REQ. With no accept, the pointer holds.
  - At most one accept per cycle.
- Issue:
  - On an accept at cycle T, mul_src1/mul_src2 take that requester's operands at the end of T.
  - An issue-valid bit and the ID are registered alongside the operands.
  - The valid/ID shift through a MUL_LATENCY-stage tag pipeline that tracks the cell.
  - mul_src1/mul_src2 hold their last values when there is no accept.
- Capture:
  - In cycle T+1+MUL_LATENCY, mul_result and its ID are written to the FIFO.
  - A write is guaranteed by the credit rule never to find the FIFO full.
- Response:
  - The FIFO head drives resp_valid/resp_id/resp_data from cycle T+2+MUL_LATENCY (T+3 at the default latency).
  - resp_id and resp_data read 0 whenever resp_valid = 0.
  - resp_valid, once high, holds with stable data until resp_ready.
  - Responses leave in accept order.
- Arithmetic: result = (src1*src2) mod 2^32. Signed and unsigned multiplies give identical results.
- busy = (pipeline tag valid anywhere) | (FIFO non-empty).
- Throughput: one operation per cycle sustained when resp_ready is held high and FIFO_DEPTH meets its minimum.
- Deasserting req_valid without a handshake is permitted; the arbiter has no memory of prior requests.

Test Plan:
- Single request: requester 2 sends src1=7, src2=6 at cycle 0 → req_ready[2]=1 in cycle 0; resp_valid in cycle 3 with resp_id=2, resp_data=42; busy high for cycles 1-3.
- Four-way contention: all four req_valid held high with distinct operands, resp_ready=1 → accepts in order 0,1,2,3,0, one per cycle; responses in the same order, back-to-back.
- Wrap-around: 0xFFFFFFFF*0xFFFFFFFF → 0x00000001; 0x00010000*0x00010000 → 0x00000000; 0x80000000*2 → 0x00000000.
- Backpressure: resp_ready=0 with requester 0 always valid → exactly 4 accepts, then req_ready stays 0. Asserting resp_ready for one cycle → exactly one pop and one new accept; all 5 results are correct and in order.
- Simultaneous accept and pop at credits=1 → credit count stays 1 and the next cycle can accept again; no FIFO overflow.
- Reset mid-operation: assert reset with 2 in flight and 1 buffered → resp_valid=0 and busy=0 immediately; after release, a new request returns only its own result, and the pointer restarts at requester 0.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// Request/response channels between the multiply users and the shared multiplier arbiter.
// The arbiter side uses the slave modport.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_src1;
    logic [NUM_REQ*32-1:0] req_src2;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_data;

    modport slave (
        input  req_valid, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

    modport master (
        output req_valid, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one non-stalling pipelined multiplier among NUM_REQ requesters.
// A credit-managed result FIFO absorbs response backpressure so no result is ever dropped.
module mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_share_arbiter_if.slave   bus,
    output logic [31:0]          mul_src1,
    output logic [31:0]          mul_src2,
    input  logic [31:0]          mul_result,
    output logic                 busy
);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W  = ID_W + 32;

    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] fifo_cnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   scan_id;
    logic              grant_found;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ID_W+4:0]   lane_base;
    logic [31:0]       sel_src1;
    logic [31:0]       sel_src2;

    logic [MUL_LATENCY:0] tag_v;
    logic [ID_W-1:0]      tag_id [MUL_LATENCY+1];

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Scan upward from the round-robin pointer; the first valid requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // A credit stands for a guaranteed FIFO slot, so the non-stalling cell can never overflow it.
    assign accept        = grant_found && (credits != '0) && !reset;
    assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

    assign lane_base = {grant_id, 5'd0};
    assign sel_src1  = bus.req_src1[lane_base +: 32];
    assign sel_src2  = bus.req_src2[lane_base +: 32];

    assign push = tag_v[MUL_LATENCY];
    assign pop  = bus.resp_valid && bus.resp_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_src1 <= '0;
            mul_src2 <= '0;
            tag_v    <= '0;
            for (int k = 0; k <= MUL_LATENCY; k++) tag_id[k] <= '0;
        end else begin
            tag_v[0] <= accept;
            if (accept) begin
                mul_src1  <= sel_src1;
                mul_src2  <= sel_src2;
                tag_id[0] <= grant_id;
            end
            for (int k = 1; k <= MUL_LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            credits <= CRED_W'(FIFO_DEPTH);
        end else begin
            if (accept) begin
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            case ({accept, pop})
                2'b10:   credits <= credits - CRED_W'(1);
                2'b01:   credits <= credits + CRED_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {tag_id[MUL_LATENCY], mul_result};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CRED_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CRED_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign bus.resp_valid = (fifo_cnt != '0);

    always_comb begin
        bus.resp_id   = '0;
        bus.resp_data = '0;
        if (fifo_cnt != '0) {bus.resp_id, bus.resp_data} = fifo_mem[rd_ptr];
    end

    assign busy = (|tag_v) || (fifo_cnt != '0);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized and directed bench for mul_share_arbiter against a queue-based behavioural model.
// The bench also stands in for the one-cycle multiplier cell.
module tb_mul_share_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int ID_W        = 2;
    localparam int MUL_LATENCY = 1;
    localparam int FIFO_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic [31:0] mul_result = '0;
    logic        busy;

    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    mul_share_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LATENCY(MUL_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result), .busy(busy)
    );

    // Multiplier cell stand-in: result valid one cycle after operands are presented.
    always @(posedge clk) mul_result <= mul_src1 * mul_src2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: credits, pointer and an ordered list of outstanding products.
    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        int              avail;
    } exp_t;

    exp_t        q[$];
    int          m_credits = FIFO_DEPTH;
    int          m_ptr = 0;
    int          cyc = 0;
    logic [31:0] m_src1 = '0;
    logic [31:0] m_src2 = '0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] e_ready;
        logic               e_valid;
        logic [31:0]        a;
        logic [31:0]        b;
        logic [31:0]        p;
        int                 g;
        if (reset) begin
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_mul_src1", mul_src1, 0);
            check("rst_mul_src2", mul_src2, 0);
            q.delete();
            m_credits = FIFO_DEPTH;
            m_ptr     = 0;
            m_src1    = '0;
            m_src2    = '0;
            cyc       = 0;
        end else begin
            g = -1;
            if (m_credits > 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && bus.req_valid[i]) g = i;
                end
            end
            e_ready = '0;
            if (g >= 0) e_ready[g] = 1'b1;
            e_valid = (q.size() > 0) && (q[0].avail <= cyc);

            check("req_ready", bus.req_ready, e_ready);
            check("resp_valid", bus.resp_valid, e_valid);
            check("resp_id", bus.resp_id, e_valid ? q[0].id : '0);
            check("resp_data", bus.resp_data, e_valid ? q[0].data : '0);
            check("busy", busy, q.size() > 0);
            check("mul_src1", mul_src1, m_src1);
            check("mul_src2", mul_src2, m_src2);

            if (e_valid && bus.resp_ready) begin
                void'(q.pop_front());
                m_credits++;
            end
            if (g >= 0) begin
                a = bus.req_src1[g*32 +: 32];
                b = bus.req_src2[g*32 +: 32];
                p = a * b;
                q.push_back('{id: ID_W'(g), data: p, avail: cyc + 2 + MUL_LATENCY});
                m_credits--;
                m_ptr  = (g + 1) % NUM_REQ;
                m_src1 = a;
                m_src2 = b;
            end
            cyc++;
        end
    end

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_operands();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_src1[i*32 +: 32] = rand_op();
            bus.req_src2[i*32 +: 32] = rand_op();
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            bus.req_valid  = '0;
            bus.resp_ready = 1'b1;
            @(negedge clk); #1;
        end
    endtask

    task automatic single_lit(input int id, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input string name);
        bit found;
        @(posedge clk); #1;
        rand_operands();
        bus.req_valid = NUM_REQ'(1) << id;
        bus.req_src1[id*32 +: 32] = a;
        bus.req_src2[id*32 +: 32] = b;
        bus.resp_ready = 1'b1;
        @(negedge clk); #1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk); #1;
            bus.req_valid = '0;
            @(negedge clk); #1;
            if (bus.resp_valid) begin
                found = 1'b1;
                check({name, "_data"}, bus.resp_data, exp);
                check({name, "_id"}, bus.resp_id, id);
            end
        end
        if (!found) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int cnt;
        bus.req_valid  = '0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request from requester 2: 7*6, response three cycles later.
        rand_operands();
        bus.req_valid = 4'b0100;
        bus.req_src1[2*32 +: 32] = 32'd7;
        bus.req_src2[2*32 +: 32] = 32'd6;
        bus.resp_ready = 1'b1;
        @(negedge clk); #1;
        check("single_ready", bus.req_ready, 4'b0100);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            bus.req_valid = '0;
            @(negedge clk); #1;
            check("single_busy", busy, c <= 3);
            check("single_valid", bus.resp_valid, c == 3);
            if (c == 3) begin
                check("single_id", bus.resp_id, 2);
                check("single_data", bus.resp_data, 42);
            end
        end

        // Wrap-around products.
        single_lit(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "wrap_ff");
        single_lit(3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "wrap_16");
        single_lit(0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, "wrap_msb");

        // Four-way contention: grants 0,1,2,3,0 and back-to-back responses in the same order.
        reset_pulse();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            rand_operands();
            bus.req_valid  = (c < 5) ? 4'b1111 : 4'b0000;
            bus.resp_ready = 1'b1;
            @(negedge clk); #1;
            if (c < 5) check("rr_ready", bus.req_ready, 4'b0001 << (c % 4));
            if (c >= 3 && c <= 7) begin
                check("rr_resp_valid", bus.resp_valid, 1);
                check("rr_resp_id", bus.resp_id, (c - 3) % 4);
            end
        end

        // Backpressure: four accepts then stall; one pop frees exactly one credit.
        reset_pulse();
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            rand_operands();
            bus.req_valid  = 4'b0001;
            bus.resp_ready = 1'b0;
            @(negedge clk); #1;
            if (bus.req_ready[0]) cnt++;
        end
        check("bp_accepts", cnt, 4);
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_pop_valid", bus.resp_valid, 1);
        check("bp_no_accept_at_zero", bus.req_ready, 0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            rand_operands();
            bus.resp_ready = 1'b0;
            @(negedge clk); #1;
            if (bus.req_ready[0]) cnt++;
        end
        check("bp_reaccept", cnt, 1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            bus.req_valid  = '0;
            bus.resp_ready = 1'b1;
            @(negedge clk); #1;
            if (bus.resp_valid) cnt++;
        end
        check("bp_drain_pops", cnt, 4);

        // Simultaneous accept and pop with one credit left.
        reset_pulse();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rand_operands();
            bus.req_valid  = 4'b0001;
            bus.resp_ready = 1'b0;
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        rand_operands();
        bus.resp_ready = 1'b1;
        @(negedge clk); #1;
        check("sim_ready", bus.req_ready, 4'b0001);
        check("sim_pop", bus.resp_valid, 1);
        @(posedge clk); #1;
        rand_operands();
        bus.resp_ready = 1'b0;
        @(negedge clk); #1;
        check("sim_next_accept", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("sim_credits_out", bus.req_ready, 0);
        drain(10);

        // Reset with two results in flight and one buffered.
        reset_pulse();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rand_operands();
            bus.req_valid  = 4'b0010;
            bus.resp_ready = 1'b0;
            @(negedge clk); #1;
        end
        check("mid_busy_before", busy, 1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        reset = 1'b1;
        #1;
        check("mid_resp_valid", bus.resp_valid, 0);
        check("mid_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_src1  = {4{32'd3}};
        bus.req_src2  = {4{32'd5}};
        bus.req_src1[31:0] = 32'd3;
        bus.req_src2[31:0] = 32'd5;
        bus.resp_ready = 1'b1;
        @(negedge clk); #1;
        check("mid_ptr_restart", bus.req_ready, 4'b0001);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            bus.req_valid = '0;
            @(negedge clk); #1;
            if (bus.resp_valid) begin
                cnt++;
                check("mid_resp_id", bus.resp_id, 0);
                check("mid_resp_data", bus.resp_data, 15);
            end
        end
        check("mid_resp_count", cnt, 1);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rand_operands();
            bus.req_valid  = NUM_REQ'($urandom);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk); #1;
        end
        drain(20);
        check("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
